// File: rtl/lsu_mem_if_if.sv
// Request/response and data-memory bus between the core, the LSU and memory.
// Signal names carry the LSU's point of view (_i into the LSU, _o out of it).
interface lsu_mem_if_if #(
  parameter int unsigned X_LEN = 32
);

  // Core request
  logic             req_valid_i;
  logic             req_ready_o;
  logic             req_we_i;
  logic [1:0]       req_size_i;
  logic             req_unsigned_i;
  logic [X_LEN-1:0] req_addr_i;
  logic [X_LEN-1:0] req_wdata_i;

  // Core response
  logic             rsp_valid_o;
  logic [X_LEN-1:0] rsp_rdata_o;
  logic             rsp_err_o;

  // Word-organised data memory
  logic             mem_we_o;
  logic [X_LEN-1:0] mem_addr_o;
  logic [X_LEN-1:0] mem_wdata_o;
  logic [X_LEN-1:0] mem_rdata_i;

  // LSU side
  modport slave (
    input  req_valid_i, req_we_i, req_size_i, req_unsigned_i, req_addr_i, req_wdata_i,
    input  mem_rdata_i,
    output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
    output mem_we_o, mem_addr_o, mem_wdata_o
  );

  // Core plus memory side
  modport master (
    output req_valid_i, req_we_i, req_size_i, req_unsigned_i, req_addr_i, req_wdata_i,
    output mem_rdata_i,
    input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
    input  mem_we_o, mem_addr_o, mem_wdata_o
  );

endinterface

// File: rtl/lsu_mem_if.sv
// Load/store unit: turns byte/half/word loads and stores into whole-word
// memory accesses. Sub-word stores are read-modify-write; loads are sign- or
// zero-extended.
// Build option LSU_MISALIGN_TRAP_EN: when defined, misaligned or illegal-size
// requests complete with rsp_err_o; when undefined, the address is forced
// size-aligned, size 11 is treated as word and rsp_err_o is tied low.
module lsu_mem_if #(
  parameter int unsigned X_LEN = 32
) (
  input logic         clk_i,
  input logic         rst_i,
  lsu_mem_if_if.slave bus
);

  localparam int unsigned SIZE_W = 2;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned HALF_W = 16;

  localparam logic [SIZE_W-1:0] SZ_B   = 2'b00;
  localparam logic [SIZE_W-1:0] SZ_H   = 2'b01;
  localparam logic [SIZE_W-1:0] SZ_W   = 2'b10;
  localparam logic [SIZE_W-1:0] SZ_ILL = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_WR   = 3'd2,
    S_RSP  = 3'd3,
    S_ERR  = 3'd4
  } state_e;

  typedef struct packed {
    logic              we;
    logic [SIZE_W-1:0] size;
    logic              uns;
    logic [X_LEN-1:0]  addr;
    logic [X_LEN-1:0]  wdata;
  } req_t;

  state_e           state_q, state_d;
  req_t             req_in, req_q, req_d;
  logic [X_LEN-1:0] rd_q, rd_d;
  logic             misalign;
  logic             accept;

  logic             ready_q, ready_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             rsp_err_q, rsp_err_d;
  logic [X_LEN-1:0] rsp_rdata_q, rsp_rdata_d;
  logic             mem_we_q, mem_we_d;
  logic [X_LEN-1:0] mem_wdata_q, mem_wdata_d;

  // Select the addressed byte/half of a word and extend it to X_LEN.
  function automatic logic [X_LEN-1:0] load_ext(
    input logic [X_LEN-1:0]  w,
    input logic [SIZE_W-1:0] size,
    input logic              uns,
    input logic [1:0]        lane
  );
    logic [BYTE_W-1:0] b;
    logic [HALF_W-1:0] h;
    logic [X_LEN-1:0]  r;
    b = w[{lane, 3'b000} +: BYTE_W];
    h = w[{lane[1], 4'b0000} +: HALF_W];
    case (size)
      SZ_B:    r = uns ? X_LEN'(b) : {{(X_LEN-BYTE_W){b[BYTE_W-1]}}, b};
      SZ_H:    r = uns ? X_LEN'(h) : {{(X_LEN-HALF_W){h[HALF_W-1]}}, h};
      default: r = w;
    endcase
    return r;
  endfunction

  // Replace the addressed byte/half of the old word; a word store replaces all.
  function automatic logic [X_LEN-1:0] store_merge(
    input logic [X_LEN-1:0]  w,
    input logic [X_LEN-1:0]  d,
    input logic [SIZE_W-1:0] size,
    input logic [1:0]        lane
  );
    logic [X_LEN-1:0] r;
    r = w;
    case (size)
      SZ_B:    r[{lane, 3'b000} +: BYTE_W]    = d[BYTE_W-1:0];
      SZ_H:    r[{lane[1], 4'b0000} +: HALF_W] = d[HALF_W-1:0];
      default: r = d;
    endcase
    return r;
  endfunction

  // Normalise the incoming request and classify it.
  always_comb begin
    req_in.we    = bus.req_we_i;
    req_in.size  = bus.req_size_i;
    req_in.uns   = bus.req_unsigned_i;
    req_in.addr  = bus.req_addr_i;
    req_in.wdata = bus.req_wdata_i;
    misalign     = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
    case (req_in.size)
      SZ_B:    misalign = 1'b0;
      SZ_H:    misalign = req_in.addr[0];
      SZ_W:    misalign = (req_in.addr[1:0] != 2'b00);
      default: misalign = 1'b1;
    endcase
`else
    if (req_in.size == SZ_ILL) begin
      req_in.size = SZ_W;
    end
    if (req_in.size == SZ_H) begin
      req_in.addr[0] = 1'b0;
    end
    if (req_in.size == SZ_W) begin
      req_in.addr[1:0] = 2'b00;
    end
`endif
  end

  assign accept = (state_q == S_IDLE) && bus.req_valid_i;

  // Captured request and read-word next values; both hold between accepts.
  always_comb begin
    req_d = req_q;
    rd_d  = rd_q;
    if (accept) begin
      req_d = req_in;
    end
    if (state_q == S_RD) begin
      rd_d = bus.mem_rdata_i;
    end
  end

  // Request and read-word registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      req_q <= '0;
      rd_q  <= '0;
    end else begin
      req_q <= req_d;
      rd_q  <= rd_d;
    end
  end

  // FSM state register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (misalign) begin
            state_d = S_ERR;
          end else if (req_in.we && (req_in.size == SZ_W)) begin
            state_d = S_WR;
          end else begin
            state_d = S_RD;
          end
        end
      end
      S_RD:    state_d = req_q.we ? S_WR : S_RSP;
      S_WR:    state_d = S_RSP;
      S_RSP:   state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM output logic: next values of the registered outputs.
  always_comb begin
    ready_d     = (state_d == S_IDLE);
    rsp_valid_d = (state_d == S_RSP) || (state_d == S_ERR);
`ifdef LSU_MISALIGN_TRAP_EN
    rsp_err_d   = (state_d == S_ERR);
`else
    rsp_err_d   = 1'b0;
`endif
    mem_we_d    = (state_d == S_WR);
    rsp_rdata_d = rsp_rdata_q;
    mem_wdata_d = mem_wdata_q;
    if (state_d == S_ERR) begin
      rsp_rdata_d = '0;
    end else if (state_d == S_RSP) begin
      rsp_rdata_d = req_d.we ? '0 : load_ext(rd_d, req_d.size, req_d.uns, req_d.addr[1:0]);
    end
    if ((state_d == S_WR) && (state_q != S_WR)) begin
      mem_wdata_d = store_merge(rd_d, req_d.wdata, req_d.size, req_d.addr[1:0]);
    end
  end

  // Output registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ready_q     <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= '0;
    end else begin
      ready_q     <= ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
      mem_we_q    <= mem_we_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign bus.req_ready_o = ready_q;
  assign bus.rsp_valid_o = rsp_valid_q;
  assign bus.rsp_err_o   = rsp_err_q;
  assign bus.rsp_rdata_o = rsp_rdata_q;
  // Reset mid-write must not reach the memory, so the enable is gated by rst_i.
  assign bus.mem_we_o    = mem_we_q && !rst_i;
  assign bus.mem_addr_o  = {req_q.addr[X_LEN-1:2], 2'b00};
  assign bus.mem_wdata_o = mem_wdata_q;

endmodule

// File: tb/tb_lsu_mem_if.sv
// Directed bench for lsu_mem_if with a small word memory model.
module tb_lsu_mem_if;

  logic        clk;
  logic        rst;
  logic        mem_init;
  logic [31:0] mem [0:63];
  int          wr_cnt;
  int          total;
  int          bad;

  lsu_mem_if_if #(.X_LEN(32)) bus ();

  lsu_mem_if #(.X_LEN(32)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign bus.mem_rdata_i = mem[bus.mem_addr_o[7:2]];

  // Memory model: preload on mem_init, otherwise write on mem_we_o.
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
      mem[10] <= 32'h8899AABC;
      wr_cnt  <= 0;
    end else if (bus.mem_we_o) begin
      mem[bus.mem_addr_o[7:2]] <= bus.mem_wdata_o;
      wr_cnt <= wr_cnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // One request; checks latency, response and memory write activity.
  task automatic run(input string tag, input logic we, input logic [1:0] sz, input logic uns,
                     input logic [31:0] addr, input logic [31:0] wd,
                     input int exp_lat, input logic [31:0] exp_rdata, input logic exp_err,
                     input int exp_we_n, input int exp_we_at, input logic [31:0] exp_we_data,
                     input logic [31:0] exp_we_addr);
    int          lat;
    int          we_n;
    int          we_at;
    int          busy_rdy;
    logic [31:0] rdata;
    logic [31:0] we_data;
    logic [31:0] we_addr;
    logic        err;
    @(negedge clk);
    chk({tag, "_rdy"}, 32'(bus.req_ready_o), 32'd1);
    bus.req_valid_i    = 1'b1;
    bus.req_we_i       = we;
    bus.req_size_i     = sz;
    bus.req_unsigned_i = uns;
    bus.req_addr_i     = addr;
    bus.req_wdata_i    = wd;
    @(posedge clk);
    #1;
    bus.req_valid_i = 1'b0;
    lat = 0; we_n = 0; we_at = 0; busy_rdy = 0;
    rdata = 32'h0; we_data = 32'h0; we_addr = 32'h0; err = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (bus.mem_we_o) begin
        we_n++;
        we_at   = i;
        we_data = bus.mem_wdata_o;
        we_addr = bus.mem_addr_o;
      end
      if (bus.rsp_valid_o) begin
        lat   = i;
        rdata = bus.rsp_rdata_o;
        err   = bus.rsp_err_o;
        break;
      end
      if (bus.req_ready_o) busy_rdy++;
    end
    chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_rdata"}, rdata, exp_rdata);
    chk({tag, "_err"}, 32'(err), 32'(exp_err));
    chk({tag, "_we_n"}, 32'(we_n), 32'(exp_we_n));
    chk({tag, "_busy_rdy"}, 32'(busy_rdy), 32'd0);
    if (exp_we_n > 0) begin
      chk({tag, "_we_at"}, 32'(we_at), 32'(exp_we_at));
      chk({tag, "_we_data"}, we_data, exp_we_data);
      chk({tag, "_we_addr"}, we_addr, exp_we_addr);
    end
  endtask

  initial begin
    int w0;
    int saw;
    total = 0;
    bad   = 0;
    rst = 1'b1;
    mem_init = 1'b1;
    bus.req_valid_i    = 1'b0;
    bus.req_we_i       = 1'b0;
    bus.req_size_i     = 2'b00;
    bus.req_unsigned_i = 1'b0;
    bus.req_addr_i     = 32'h0;
    bus.req_wdata_i    = 32'h0;
    repeat (2) @(negedge clk);

    chk("rst_ready", 32'(bus.req_ready_o), 32'd1);
    chk("rst_valid", 32'(bus.rsp_valid_o), 32'd0);
    chk("rst_rdata", bus.rsp_rdata_o, 32'h0);
    chk("rst_err", 32'(bus.rsp_err_o), 32'd0);
    chk("rst_we", 32'(bus.mem_we_o), 32'd0);
    chk("rst_maddr", bus.mem_addr_o, 32'h0);
    chk("rst_mwdata", bus.mem_wdata_o, 32'h0);
    mem_init = 1'b0;
    rst = 1'b0;

    // Loads from the word 0x8899AABC at 0x28.
    run("ldb_s29", 1'b0, 2'b00, 1'b0, 32'h29, 32'h0, 2, 32'hFFFFFFAA, 1'b0, 0, 0, 32'h0, 32'h0);
    run("ldh_u2a", 1'b0, 2'b01, 1'b1, 32'h2A, 32'h0, 2, 32'h00008899, 1'b0, 0, 0, 32'h0, 32'h0);
    run("ldb_u28", 1'b0, 2'b00, 1'b1, 32'h28, 32'h0, 2, 32'h000000BC, 1'b0, 0, 0, 32'h0, 32'h0);
    run("ldb_s2b", 1'b0, 2'b00, 1'b0, 32'h2B, 32'h0, 2, 32'hFFFFFF88, 1'b0, 0, 0, 32'h0, 32'h0);
    run("ldh_s28", 1'b0, 2'b01, 1'b0, 32'h28, 32'h0, 2, 32'hFFFFAABC, 1'b0, 0, 0, 32'h0, 32'h0);

    // Sub-word stores merge into the old word.
    run("stb_2b", 1'b1, 2'b00, 1'b0, 32'h2B, 32'hFFFFFF11, 3, 32'h0, 1'b0, 1, 2, 32'h1199AABC, 32'h28);
    run("ldw_28a", 1'b0, 2'b10, 1'b0, 32'h28, 32'h0, 2, 32'h1199AABC, 1'b0, 0, 0, 32'h0, 32'h0);
    run("sth_28", 1'b1, 2'b01, 1'b0, 32'h28, 32'hABCD5566, 3, 32'h0, 1'b0, 1, 2, 32'h11995566, 32'h28);
    chk("mem_28", mem[10], 32'h11995566);

    // Word store skips the read.
    run("stw_40", 1'b1, 2'b10, 1'b0, 32'h40, 32'hDEADBEEF, 2, 32'h0, 1'b0, 1, 1, 32'hDEADBEEF, 32'h40);

`ifdef LSU_MISALIGN_TRAP_EN
    run("ldw_42", 1'b0, 2'b10, 1'b0, 32'h42, 32'h0, 1, 32'h0, 1'b1, 0, 0, 32'h0, 32'h0);
    run("ldh_41", 1'b0, 2'b01, 1'b0, 32'h41, 32'h0, 1, 32'h0, 1'b1, 0, 0, 32'h0, 32'h0);
    run("ld_ill", 1'b0, 2'b11, 1'b0, 32'h40, 32'h0, 1, 32'h0, 1'b1, 0, 0, 32'h0, 32'h0);
    run("stw_41", 1'b1, 2'b10, 1'b0, 32'h41, 32'h12345678, 1, 32'h0, 1'b1, 0, 0, 32'h0, 32'h0);
`else
    run("ldw_42", 1'b0, 2'b10, 1'b0, 32'h42, 32'h0, 2, 32'hDEADBEEF, 1'b0, 0, 0, 32'h0, 32'h0);
    run("ldh_41", 1'b0, 2'b01, 1'b0, 32'h41, 32'h0, 2, 32'hFFFFBEEF, 1'b0, 0, 0, 32'h0, 32'h0);
    run("ld_ill", 1'b0, 2'b11, 1'b0, 32'h41, 32'h0, 2, 32'hDEADBEEF, 1'b0, 0, 0, 32'h0, 32'h0);
`endif
    chk("mem_40", mem[16], 32'hDEADBEEF);

    // Reset arriving in the write cycle of a sub-word store.
    @(negedge clk);
    bus.req_valid_i    = 1'b1;
    bus.req_we_i       = 1'b1;
    bus.req_size_i     = 2'b00;
    bus.req_unsigned_i = 1'b0;
    bus.req_addr_i     = 32'h41;
    bus.req_wdata_i    = 32'h000000AA;
    @(posedge clk);
    #1;
    bus.req_valid_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rmw_we_pre", 32'(bus.mem_we_o), 32'd1);
    w0  = wr_cnt;
    rst = 1'b1;
    #1;
    chk("rmw_we_rst", 32'(bus.mem_we_o), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    chk("rmw_rdy", 32'(bus.req_ready_o), 32'd1);
    saw = 0;
    if (bus.rsp_valid_o) saw++;
    repeat (3) begin
      @(negedge clk);
      if (bus.rsp_valid_o) saw++;
    end
    chk("rmw_norsp", 32'(saw), 32'd0);
    chk("rmw_wrcnt", 32'(wr_cnt), 32'(w0));
    chk("rmw_mem", mem[16], 32'hDEADBEEF);
    run("ldw_40", 1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 2, 32'hDEADBEEF, 1'b0, 0, 0, 32'h0, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lsu_mem_if.md
Name: lsu_mem_if

Overview:
- Load/store unit between the execute-stage ALU result and the word-organised data memory.
- Converts byte, halfword and word load/store requests into word-wide memory accesses.
- Sub-word stores use read-modify-write because the memory has only a whole-word write enable.
- Loads are sign- or zero-extended.
- Multi-cycle request/response handshake; the core stalls on req_ready_o.

Parameters:
- X_LEN, 32, datapath and address width. Only 32 is supported.

Ports:
- clk_i  in  1  clock. All state updates on rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- req_valid_i  in  1  request present.
- req_ready_o  out  1  unit can accept a request.
- req_we_i  in  1  1 = store, 0 = load.
- req_size_i  in  2  00 byte, 01 half, 10 word, 11 illegal.
- req_unsigned_i  in  1  loads only: 1 = zero-extend, 0 = sign-extend.
- req_addr_i  in  X_LEN  byte address.
- req_wdata_i  in  X_LEN  store data, right-justified.
- rsp_valid_o  out  1  one-cycle completion pulse.
- rsp_rdata_o  out  X_LEN  extended load data; 0 for stores and errors.
- rsp_err_o  out  1  misaligned or illegal-size request; valid with rsp_valid_o.
- mem_we_o  out  1  memory word write enable.
- mem_addr_o  out  X_LEN  word-aligned byte address: request address bits [31:2] with bits [1:0] forced to 00.
- mem_wdata_o  out  X_LEN  full word to write.
- mem_rdata_i  in  X_LEN  memory read data, combinational from mem_addr_o.

Behaviour:
- Reset: state IDLE; req_ready_o=1; rsp_valid_o=0; rsp_rdata_o=0; rsp_err_o=0; mem_we_o=0; mem_addr_o=0; mem_wdata_o=0; all request registers cleared.
- Accept: on the edge where req_valid_i && req_ready_o, capture we, size, unsigned, addr and wdata.
- req_ready_o is high only in IDLE. Inputs are ignored in all other states.
- mem_addr_o is driven from the captured address in every non-IDLE state.
- States:
  - IDLE to ERR if the request is misaligned or the size is illegal.
  - IDLE to WR for a word store.
  - IDLE to RD for loads and sub-word stores.
  - RD: register mem_rdata_i into rd_q. Go to RSP for a load, WR for a store.
  - WR: mem_we_o=1 for exactly this cycle. Go to RSP.
  - RSP: rsp_valid_o=1, rsp_err_o=0. Go to IDLE.
  - ERR: rsp_valid_o=1, rsp_err_o=1, rsp_rdata_o=0. No memory write. Go to IDLE.
- Latency from accept edge to rsp_valid_o:
  - Load: 2 cycles.
  - Word store: 2 cycles.
  - Sub-word store: 3 cycles.
  - Error: 1 cycle.
- Misaligned definitions:
  - Half: addr[0]=1.
  - Word: addr[1:0] != 00.
  - Byte: never misaligned.
- Load extraction:
  - Byte lane = addr[1:0], taken from bits [8*lane+7 : 8*lane] of rd_q.
  - Half lane = addr[1], taken from bits [16*addr[1]+15 : 16*addr[1]].
  - The extracted value is extended to X_LEN using req_unsigned_i.
  - Word: rd_q unchanged.
- Store merge: mem_wdata_o = rd_q with the selected byte or half lane replaced by the low 8/16 bits of wdata. Other lanes are preserved bit-exact. Word store: mem_wdata_o = wdata; rd_q is unused.
- Store response: rsp_rdata_o=0.
- Register reuse: rd_q and the captured request hold until the next accept; the outputs change only then.
- Reset mid-operation: mem_we_o is forced 0 in any cycle where rst_i=1, so no partial write occurs even when reset arrives in WR. The next state is IDLE. The pending response is dropped, with no rsp_valid_o.
- Back-to-back: a new request is accepted in the IDLE cycle after RSP or ERR. Minimum issue interval is 3 cycles for a load, 4 for a sub-word store.
- rsp_valid_o has no backpressure; the consumer must take it.

Optional Feature:
- Macro: LSU_MISALIGN_TRAP_EN.
- Defined: behaviour exactly as specified above, with the ERR state and rsp_err_o.
- Undefined: ERR is never entered and rsp_err_o is tied to 0.
  - The address is forced size-aligned: half clears addr[0]; word clears addr[1:0].
  - Illegal size 11 is treated as word.
  - The access then proceeds normally.

Test Plan:
- Word at byte address 0x28 = 0x8899AABC; load byte, signed, addr 0x29 -> rsp 2 cycles after accept, rsp_rdata_o=0xFFFFFFAA, rsp_err_o=0.
- Same word; load half, unsigned, addr 0x2A -> rsp_rdata_o=0x00008899.
- Same word; store byte 0x11 to addr 0x2B -> mem_we_o exactly one cycle with mem_wdata_o=0x1199AABC and mem_addr_o=0x28; a following word load returns 0x1199AABC.
- Word store 0xDEADBEEF to 0x40 -> no RD state, mem_we_o in the cycle after accept, rsp_valid_o the next cycle.
- Load word at 0x42:
  - With LSU_MISALIGN_TRAP_EN: rsp_valid_o and rsp_err_o one cycle after accept, rsp_rdata_o=0, mem_we_o never asserted.
  - Without it: returns the word at 0x40.
- Sub-word store with rst_i asserted in the WR cycle -> mem_we_o stays 0 and the memory is unchanged, no rsp_valid_o, req_ready_o=1 the next cycle.
